// File: rtl/cpu_control_unit.sv
// Multi-cycle control sequencer: fetches at the PC, decodes the IR into datapath
// controls, runs the load/store handshake and owns the PC, halt and fault state.
module cpu_control_unit #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_instr,
   input  logic        i_mem_ack,
   input  logic        i_nflag,
   input  logic        i_zflag,
   input  logic        i_vflag,
   input  logic        i_cflag,
   output logic [3:0]  o_sel_a,
   output logic [3:0]  o_sel_b,
   output logic [3:0]  o_dr,
   output logic        o_rw,
   output logic [4:0]  o_fs,
   output logic        o_mb,
   output logic [31:0] o_mb_data,
   output logic        o_mm,
   output logic        o_md,
   output logic [7:0]  o_pc,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic        o_halt,
   output logic        o_fault
);

   typedef enum logic [2:0] {S_RST, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   localparam logic [3:0] CLS_ALU_R = 4'h0;
   localparam logic [3:0] CLS_ALU_I = 4'h1;
   localparam logic [3:0] CLS_LOAD  = 4'h2;
   localparam logic [3:0] CLS_STORE = 4'h3;
   localparam logic [3:0] CLS_BR    = 4'h4;
   localparam logic [3:0] CLS_JMP   = 4'h5;
   localparam logic [3:0] CLS_HALT  = 4'hF;

   // Counter only has to reach TIMEOUT-1: the last waiting cycle decides the fault.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [7:0]      pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic            fault_q, fault_d;
   logic [CW-1:0]   wait_q, wait_d;
   logic [3:0]      cls;
   logic            br_take;
   logic            tmo;
   logic            unused_ir;

   assign cls       = ir_q[31:28];
   assign o_fs      = ir_q[27:23];
   assign o_dr      = ir_q[22:19];
   assign o_sel_a   = ir_q[18:15];
   assign o_sel_b   = ir_q[14:11];
   assign o_mb_data = {{24{ir_q[7]}}, ir_q[7:0]};
   assign o_pc      = pc_q;
   assign o_fault   = fault_q;
   assign unused_ir = ^ir_q[10:8];
   assign tmo       = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

   always_comb begin
      case (ir_q[22:19])
         4'd0:    br_take = 1'b1;
         4'd1:    br_take = i_zflag;
         4'd2:    br_take = ~i_zflag;
         4'd3:    br_take = i_nflag;
         4'd4:    br_take = i_cflag;
         4'd5:    br_take = i_vflag;
         default: br_take = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_RST;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         fault_q <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         fault_q <= fault_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      fault_d   = fault_q;
      wait_d    = wait_q;
      o_mm      = 1'b0;
      o_md      = 1'b0;
      o_mb      = 1'b0;
      o_rw      = 1'b0;
      o_mem_req = 1'b0;
      o_mem_we  = 1'b0;
      o_halt    = 1'b0;
      case (state_q)
         S_RST: begin
            wait_d  = '0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            o_mm      = 1'b1;
            o_mem_req = 1'b1;
            if (i_mem_ack) begin
               ir_d    = i_instr;
               state_d = S_EXEC;
            end else if (tmo) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_EXEC: begin
            wait_d  = '0;
            state_d = S_FETCH;
            case (cls)
               CLS_ALU_R, CLS_ALU_I: begin
                  o_rw = 1'b1;
                  o_mb = (cls == CLS_ALU_I);
                  pc_d = pc_q + 8'd1;
               end
               CLS_LOAD, CLS_STORE: state_d = S_MEM;
               // Modulo-256 add of the raw byte equals adding its sign extension.
               CLS_BR:   pc_d = br_take ? (pc_q + ir_q[7:0]) : (pc_q + 8'd1);
               CLS_JMP:  pc_d = ir_q[7:0];
               CLS_HALT: state_d = S_HALT;
               default: begin
                  fault_d = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end
         S_MEM: begin
            o_mem_req = 1'b1;
            if (cls == CLS_LOAD) begin
               o_md = 1'b1;
               o_rw = i_mem_ack;
            end else begin
               o_mem_we = 1'b1;
            end
            if (i_mem_ack) begin
               pc_d    = pc_q + 8'd1;
               wait_d  = '0;
               state_d = S_FETCH;
            end else if (tmo) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_HALT: o_halt = 1'b1;
         default: state_d = S_RST;
      endcase
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized scoreboard bench for cpu_control_unit: an instruction-level model
// predicts the memory/write/halt events the sequencer must present.
module tb_cpu_control_unit;

   localparam logic [7:0] RST_PC = 8'h00;
   localparam logic [1:0] K_FETCH = 2'd0, K_MEM = 2'd1, K_WR = 2'd2, K_HALT = 2'd3;
   localparam logic [31:0] HALT_INS = 32'hF000_0000;

   typedef struct packed {
      logic [1:0]  kind;
      logic        mm, we, md, rw, mb, fault;
      logic [7:0]  pc;
      logic [3:0]  a, b, dr;
      logic [4:0]  fs;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] i_instr;
   logic i_mem_ack, i_nflag, i_zflag, i_vflag, i_cflag;
   logic [3:0] o_sel_a, o_sel_b, o_dr;
   logic o_rw, o_mb, o_mm, o_md, o_mem_req, o_mem_we, o_halt, o_fault;
   logic [4:0] o_fs;
   logic [31:0] o_mb_data;
   logic [7:0] o_pc;

   logic t_rst = 1'b1;
   logic [31:0] t_instr = 32'h0;
   logic t_ack = 1'b0;
   logic [3:0] t_sel_a, t_sel_b, t_dr;
   logic t_rw, t_mb, t_mm, t_md, t_req, t_we, t_halt, t_fault;
   logic [4:0] t_fs;
   logic [31:0] t_mb_data;
   logic [7:0] t_pc;

   logic [31:0] mem [256];
   ev_t exp_q[$];
   int total = 0, bad = 0, ev_n = 0;
   int dly_lo = 0, dly_hi = 0;
   bit run_en = 0, halt_seen = 0;

   always #5 clk = ~clk;

   cpu_control_unit #(.RESET_PC(RST_PC), .TIMEOUT(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_instr(i_instr), .i_mem_ack(i_mem_ack),
      .i_nflag(i_nflag), .i_zflag(i_zflag), .i_vflag(i_vflag), .i_cflag(i_cflag),
      .o_sel_a(o_sel_a), .o_sel_b(o_sel_b), .o_dr(o_dr), .o_rw(o_rw), .o_fs(o_fs),
      .o_mb(o_mb), .o_mb_data(o_mb_data), .o_mm(o_mm), .o_md(o_md), .o_pc(o_pc),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_halt(o_halt), .o_fault(o_fault));

   cpu_control_unit #(.RESET_PC(8'h40), .TIMEOUT(4)) dut_to (
      .i_clk(clk), .i_rst(t_rst), .i_instr(t_instr), .i_mem_ack(t_ack),
      .i_nflag(1'b0), .i_zflag(1'b0), .i_vflag(1'b0), .i_cflag(1'b0),
      .o_sel_a(t_sel_a), .o_sel_b(t_sel_b), .o_dr(t_dr), .o_rw(t_rw), .o_fs(t_fs),
      .o_mb(t_mb), .o_mb_data(t_mb_data), .o_mm(t_mm), .o_md(t_md), .o_pc(t_pc),
      .o_mem_req(t_req), .o_mem_we(t_we), .o_halt(t_halt), .o_fault(t_fault));

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   function automatic logic [31:0] mk(input logic [3:0] cls, input logic [4:0] fs,
                                      input logic [3:0] dr, input logic [3:0] sa,
                                      input logic [3:0] sb, input logic [7:0] imm);
      return {cls, fs, dr, sa, sb, 3'b000, imm};
   endfunction

   function automatic ev_t ir_ev(input logic [7:0] pc, input logic [31:0] ins);
      ev_t e = '0;
      e.pc = pc; e.fs = ins[27:23]; e.dr = ins[22:19];
      e.a = ins[18:15]; e.b = ins[14:11];
      e.data = {{24{ins[7]}}, ins[7:0]};
      return e;
   endfunction

   function automatic ev_t obs(input logic [1:0] k);
      ev_t e;
      e.kind = k; e.mm = o_mm; e.we = o_mem_we; e.md = o_md; e.rw = o_rw;
      e.mb = o_mb; e.fault = o_fault; e.pc = o_pc;
      e.a = o_sel_a; e.b = o_sel_b; e.dr = o_dr; e.fs = o_fs; e.data = o_mb_data;
      if (k == K_FETCH) begin
         e.a = '0; e.b = '0; e.dr = '0; e.fs = '0; e.data = '0;
      end
      return e;
   endfunction

   // Instruction-level interpreter: one fetch per instruction, plus its visible effect.
   task automatic model(input int maxi, output bit halted, output bit flt, output logic [7:0] end_pc);
      int pc, t;
      logic [31:0] ins;
      ev_t e;
      bit take;
      pc = int'(RST_PC); halted = 0; flt = 0;
      for (int n = 0; n < maxi && !halted; n++) begin
         ins = mem[pc];
         e = '0; e.kind = K_FETCH; e.mm = 1'b1; e.pc = 8'(pc);
         exp_q.push_back(e);
         e = ir_ev(8'(pc), ins);
         case (ins[31:28])
            4'h0, 4'h1: begin
               e.kind = K_WR; e.rw = 1'b1; e.mb = (ins[31:28] == 4'h1);
               exp_q.push_back(e); pc = (pc + 1) % 256;
            end
            4'h2: begin
               e.kind = K_MEM; e.md = 1'b1; e.rw = 1'b1;
               exp_q.push_back(e); pc = (pc + 1) % 256;
            end
            4'h3: begin
               e.kind = K_MEM; e.we = 1'b1;
               exp_q.push_back(e); pc = (pc + 1) % 256;
            end
            4'h4: begin
               case (int'(ins[22:19]))
                  0: take = 1;
                  1: take = i_zflag;
                  2: take = !i_zflag;
                  3: take = i_nflag;
                  4: take = i_cflag;
                  5: take = i_vflag;
                  default: take = 0;
               endcase
               t = take ? pc + int'($signed(ins[7:0])) : pc + 1;
               pc = (t + 256) % 256;
            end
            4'h5: pc = int'(ins[7:0]);
            default: begin
               flt = (ins[31:28] != 4'hF);
               e.kind = K_HALT; e.fault = flt;
               exp_q.push_back(e); halted = 1;
            end
         endcase
      end
      end_pc = 8'(pc);
   endtask

   // Memory responder: random ack latency per access, random ack noise when idle.
   initial begin
      int dly;
      bit busy;
      dly = 0; busy = 0; i_mem_ack = 1'b0; i_instr = '0;
      forever begin
         @(posedge clk); #2;
         if (o_mem_req) begin
            if (!busy) begin
               busy = 1;
               dly = int'($urandom_range(dly_hi, dly_lo));
            end
            i_instr = o_mm ? mem[o_pc] : $urandom;
            if (dly == 0) begin
               i_mem_ack = 1'b1; busy = 0;
            end else begin
               i_mem_ack = 1'b0; dly--;
            end
         end else begin
            busy = 0;
            i_mem_ack = 1'($urandom_range(1, 0));
            i_instr = $urandom;
         end
      end
   end

   // Monitor: every presented event is popped and compared against the model.
   initial begin
      ev_t act, want;
      bit got;
      forever begin
         @(negedge clk);
         if (run_en) begin
            got = 0;
            if (o_halt) begin
               if (!halt_seen) begin
                  halt_seen = 1; act = obs(K_HALT); got = 1;
               end
            end else if (o_mem_req && i_mem_ack) begin
               act = obs(o_mm ? K_FETCH : K_MEM); got = 1;
            end else if (o_rw) begin
               act = obs(K_WR); got = 1;
            end
            if (got) begin
               ev_n++;
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_event%0d: got %h want none", ev_n, act);
               end else begin
                  want = exp_q.pop_front();
                  chk($sformatf("event%0d", ev_n), 96'(act), 96'(want));
               end
            end
         end
      end
   end

   task automatic run_prog(input int maxi, input int lo, input int hi, input logic [3:0] nzvc);
      bit halted, flt;
      logic [7:0] end_pc;
      int cyc;
      {i_nflag, i_zflag, i_vflag, i_cflag} = nzvc;
      dly_lo = lo; dly_hi = hi;
      exp_q.delete();
      model(maxi, halted, flt, end_pc);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("reset_outs",
          96'({o_pc, o_sel_a, o_sel_b, o_dr, o_rw, o_fs, o_mb, o_mb_data, o_mm, o_md,
               o_mem_req, o_mem_we, o_halt, o_fault}),
          96'({RST_PC, 57'd0}));
      halt_seen = 0; run_en = 1; rst = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 3000) begin
         @(negedge clk); #1;
         cyc++;
      end
      run_en = 0;
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL run_timeout: got %0d pending events want 0", exp_q.size());
         exp_q.delete();
      end else if (halted) begin
         repeat (3) @(negedge clk);
         chk("halt_hold", 96'({o_halt, o_fault, o_mem_req, o_rw, o_pc}),
             96'({1'b1, flt, 1'b0, 1'b0, end_pc}));
         rst = 1'b1; #1;
         chk("post_halt_reset", 96'({o_halt, o_fault, o_mem_req, o_pc}),
             96'({1'b0, 1'b0, 1'b0, RST_PC}));
      end
      rst = 1'b1;
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) mem[i] = HALT_INS;
   endtask

   function automatic logic [31:0] rand_ins();
      int r;
      logic [31:0] w;
      r = int'($urandom_range(99, 0));
      w = $urandom;
      if      (r < 20) w[31:28] = 4'h0;
      else if (r < 35) w[31:28] = 4'h1;
      else if (r < 50) w[31:28] = 4'h2;
      else if (r < 62) w[31:28] = 4'h3;
      else if (r < 80) w[31:28] = 4'h4;
      else if (r < 90) w[31:28] = 4'h5;
      else if (r < 95) w[31:28] = 4'hF;
      else             w[31:28] = 4'($urandom_range(14, 6));
      return w;
   endfunction

   initial begin
      int cnt;
      #3_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      i_nflag = 0; i_zflag = 0; i_vflag = 0; i_cflag = 0;
      repeat (2) @(negedge clk);

      // ALU reg fs=2 dr=3 with immediate ack
      fill_halt(); mem[0] = mk(4'h0, 5'd2, 4'd3, 4'd0, 4'd0, 8'h00);
      run_prog(10, 0, 0, 4'b0000);
      // LOAD sa=4 dr=5 with three-cycle ack delay
      fill_halt(); mem[0] = mk(4'h2, 5'd0, 4'd5, 4'd4, 4'd0, 8'h00);
      run_prog(10, 3, 3, 4'b0000);
      // BRANCH on Z at pc=2 with imm -4, taken and not taken
      fill_halt(); mem[0] = mk(4'h5, 5'd0, 4'd0, 4'd0, 4'd0, 8'h02);
      mem[2] = mk(4'h4, 5'd0, 4'd1, 4'd0, 4'd0, 8'hFC);
      run_prog(10, 0, 1, 4'b0100);
      run_prog(10, 0, 1, 4'b0000);
      // JUMP to 0xFF then ALU imm wraps PC to 0x00
      fill_halt(); mem[0] = mk(4'h5, 5'd0, 4'd0, 4'd0, 4'd0, 8'hFF);
      mem[255] = mk(4'h1, 5'd9, 4'd7, 4'd1, 4'd2, 8'h85);
      run_prog(4, 0, 2, 4'b0000);
      // illegal class 7 faults
      fill_halt(); mem[0] = mk(4'h7, 5'd1, 4'd1, 4'd1, 4'd1, 8'h11);
      run_prog(10, 0, 2, 4'b0000);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = rand_ins();
         run_prog(40, 0, 4, 4'($urandom_range(15, 0)));
      end

      // reset while a load is waiting for its ack
      fill_halt(); mem[0] = mk(4'h2, 5'd0, 4'd5, 4'd4, 4'd0, 8'h00);
      dly_lo = 8; dly_hi = 8;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      cnt = 0;
      while (!(o_mem_req && !o_mm) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 50) begin
         total++; bad++;
         $display("FAIL midmem_reach: got no MEM phase want MEM phase");
      end else begin
         repeat (2) @(negedge clk);
         chk("midmem_req", 96'({o_mem_req, o_mm, o_md, o_rw}), 96'(4'b1010));
         rst = 1'b1; #1;
         chk("midmem_reset", 96'({o_mem_req, o_md, o_mem_we, o_pc}), 96'({3'b000, RST_PC}));
      end

      // fetch that never gets an ack on the TIMEOUT=4 instance
      t_rst = 1'b1; @(negedge clk);
      chk("to_reset_pc", 96'({t_pc, t_req, t_halt, t_fault}), 96'({8'h40, 3'b000}));
      t_rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (t_req) cnt++;
      end
      chk("to_req_cycles", 96'(cnt), 96'(4));
      chk("to_halt", 96'({t_halt, t_fault, t_req, t_rw, t_pc}), 96'({4'b1100, 8'h40}));
      t_rst = 1'b1; #1;
      chk("to_reset_clear", 96'({t_halt, t_fault, t_req}), 96'(3'b000));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
